// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl
// Sits between the two EX-stage branch-resolution ports and the single
// predictor update port. Resolution records that would not train the
// predictor are filtered out, the rest are queued in a small circular FIFO
// and presented one per cycle. A mispredicted ex0 kills the younger ex1
// record (wrong path). Records that do not fit are dropped and counted in a
// saturating counter.
//
// FIFO entry layout: {info[65:0], mispred, pred_true}
// info layout:       {direction[65], target[64:33], type[32], pc[31:0]}

module bpu_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     ex0_valid,
    input  logic [65:0]              ex0_info,
    input  logic                     ex0_mispred,
    input  logic                     ex0_pred_true,

    input  logic                     ex1_valid,
    input  logic [65:0]              ex1_info,
    input  logic                     ex1_mispred,
    input  logic                     ex1_pred_true,

    input  logic                     upd_ready,
    output logic                     upd_valid,
    output logic [65:0]              upd_info,
    output logic                     upd_mispred,
    output logic                     upd_pred_true,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 68;
    localparam int DW = CNT_W + 1;

    // Registered state
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Combinational helpers
    logic             want0, want1, kill1;
    logic             deq;
    logic [CW-1:0]    free;
    logic             acc0, acc1;
    logic [1:0]       n_acc, n_drop;
    logic [AW-1:0]    wr_slot1;
    logic [DW-1:0]    drop_sum;
    logic [EW-1:0]    head;

    // Decide which EX records would train the predictor; a mispredicted
    // older slot means the younger slot sat on the wrong path.
    always_comb begin
        want0 = 1'b0;
        want1 = 1'b0;
        kill1 = 1'b0;
        want0 = ex0_valid & (ex0_info[32] | ex0_mispred);
        kill1 = ex0_valid & ex0_mispred;
        want1 = ex1_valid & ~kill1 & (ex1_info[32] | ex1_mispred);
    end

    // Work out how many qualifying records fit, keeping the older one first.
    // A slot freed by this cycle's pop is usable for this cycle's push.
    always_comb begin
        deq    = 1'b0;
        free   = '0;
        acc0   = 1'b0;
        acc1   = 1'b0;
        n_acc  = '0;
        n_drop = '0;
        deq    = (count_q != '0) & upd_ready;
        free   = CW'(DEPTH) - count_q + CW'(deq);
        acc0   = want0 & (free >= CW'(1));
        acc1   = want1 & (want0 ? (free >= CW'(2)) : (free >= CW'(1)));
        n_acc  = 2'(acc0) + 2'(acc1);
        n_drop = 2'(want0 & ~acc0) + 2'(want1 & ~acc1);
    end

    // Next-state for storage, pointers, occupancy and the drop counter.
    // ex1 lands right behind ex0 when both are accepted.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        wr_slot1   = wr_ptr_q + AW'(acc0);
        drop_sum   = DW'(drop_cnt_q) + DW'(n_drop);

        if (acc0) begin
            mem_d[wr_ptr_q] = {ex0_info, ex0_mispred, ex0_pred_true};
        end
        if (acc1) begin
            mem_d[wr_slot1] = {ex1_info, ex1_mispred, ex1_pred_true};
        end

        wr_ptr_d   = wr_ptr_q + AW'(n_acc);
        rd_ptr_d   = rd_ptr_q + AW'(deq);
        count_d    = count_q + CW'(n_acc) - CW'(deq);
        drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    // State registers; reset wipes storage so the head reads back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Outputs come straight from registered storage: no path from ex* inputs.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        upd_valid     = (count_q != '0);
        upd_info      = head[EW-1:2];
        upd_mispred   = head[1];
        upd_pred_true = head[0];
        count         = count_q;
        full          = (count_q == CW'(DEPTH));
        drop_cnt      = drop_cnt_q;
    end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Testbench for bpu_update_ctrl: directed vectors, expected update records
// pushed into a scoreboard queue and checked by an independent monitor.

module tb_bpu_update_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex0_valid, ex0_mispred, ex0_pred_true;
    logic [65:0]      ex0_info;
    logic             ex1_valid, ex1_mispred, ex1_pred_true;
    logic [65:0]      ex1_info;
    logic             upd_ready;
    logic             upd_valid, upd_mispred, upd_pred_true;
    logic [65:0]      upd_info;
    logic [2:0]       count;
    logic             full;
    logic [CNT_W-1:0] drop_cnt;

    logic [67:0]      exp_q [$];
    int               n_checks = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    bpu_update_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex0_valid     (ex0_valid),
        .ex0_info      (ex0_info),
        .ex0_mispred   (ex0_mispred),
        .ex0_pred_true (ex0_pred_true),
        .ex1_valid     (ex1_valid),
        .ex1_info      (ex1_info),
        .ex1_mispred   (ex1_mispred),
        .ex1_pred_true (ex1_pred_true),
        .upd_ready     (upd_ready),
        .upd_valid     (upd_valid),
        .upd_info      (upd_info),
        .upd_mispred   (upd_mispred),
        .upd_pred_true (upd_pred_true),
        .count         (count),
        .full          (full),
        .drop_cnt      (drop_cnt)
    );

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] mk(input logic dir, input logic [31:0] tgt,
                                       input logic typ, input logic [31:0] pc);
        return {dir, tgt, typ, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex0_valid = 0; ex0_info = '0; ex0_mispred = 0; ex0_pred_true = 0;
        ex1_valid = 0; ex1_info = '0; ex1_mispred = 0; ex1_pred_true = 0;
    endtask

    task automatic drive0(input logic [65:0] info, input logic m, input logic p);
        ex0_valid = 1; ex0_info = info; ex0_mispred = m; ex0_pred_true = p;
    endtask

    task automatic drive1(input logic [65:0] info, input logic m, input logic p);
        ex1_valid = 1; ex1_info = info; ex1_mispred = m; ex1_pred_true = p;
    endtask

    // Monitor: every accepted update must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_update: got pc %h, expected no update", upd_info[31:0]);
            end else begin
                check("update_record", {upd_info, upd_mispred, upd_pred_true}, exp_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [65:0] r0, r1;
        rst = 1;
        upd_ready = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_count", count, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_full", full, 0);

        // Mid-cycle reset with a record in flight: it is lost, not counted
        step();
        drive0(mk(1, 32'h60, 1, 32'h50), 0, 1);
        step();
        idle_inputs();
        @(negedge clk);
        check("prefill_count", count, 1);
        #2 rst = 1;
        #1;
        check("async_rst_upd_valid", upd_valid, 0);
        check("async_rst_count", count, 0);
        check("async_rst_upd_info", upd_info, 0);
        check("async_rst_full", full, 0);
        check("async_rst_drop_cnt", drop_cnt, 0);
        exp_q.delete();
        step();
        rst = 0;
        upd_ready = 1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_valid", upd_valid, 0);
        end

        // Single branch, empty FIFO: visible exactly one cycle later
        step();
        r0 = mk(1, 32'hBFC00100, 1, 32'hBFC00010);
        drive0(r0, 0, 1);
        exp_q.push_back({r0, 1'b0, 1'b1});
        step();
        idle_inputs();
        @(negedge clk);
        check("single_latency_valid", upd_valid, 1);
        step();
        @(negedge clk);
        check("single_after_valid", upd_valid, 0);
        check("single_after_count", count, 0);

        // Correctly predicted jump filtered, ex1 branch kept
        step();
        r0 = mk(0, 32'h280, 0, 32'h200);
        r1 = mk(1, 32'h240, 1, 32'h204);
        drive0(r0, 0, 1);
        drive1(r1, 0, 0);
        exp_q.push_back({r1, 1'b0, 1'b0});
        step();
        idle_inputs();
        @(negedge clk);
        check("filter_jump_count", count, 1);
        step();

        // Mispredicted jump trains, younger ex1 killed without drop
        r0 = mk(1, 32'h400, 0, 32'h300);
        r1 = mk(1, 32'h340, 1, 32'h304);
        drive0(r0, 1, 0);
        drive1(r1, 0, 1);
        exp_q.push_back({r0, 1'b1, 1'b0});
        step();
        idle_inputs();
        @(negedge clk);
        check("kill_count", count, 1);
        step();
        @(negedge clk);
        check("kill_drop_cnt", drop_cnt, 0);
        check("kill_count_drained", count, 0);

        // Dual enqueue order
        step();
        r0 = mk(0, 32'h180, 1, 32'h100);
        r1 = mk(1, 32'h1A0, 1, 32'h104);
        drive0(r0, 0, 1);
        drive1(r1, 1, 0);
        exp_q.push_back({r0, 1'b0, 1'b1});
        exp_q.push_back({r1, 1'b1, 1'b0});
        step();
        idle_inputs();
        @(negedge clk);
        check("dual_count_2", count, 2);
        step();
        @(negedge clk);
        check("dual_count_1", count, 1);
        step();
        @(negedge clk);
        check("dual_count_0", count, 0);

        // Overflow: three dual-branch cycles with the predictor stalled
        step();
        upd_ready = 0;
        for (int k = 0; k < 3; k++) begin
            r0 = mk(1, 32'h8000 + 32'(k), 1, 32'h1000 + 32'(k * 16));
            r1 = mk(0, 32'h9000 + 32'(k), 1, 32'h1004 + 32'(k * 16));
            drive0(r0, 0, 1);
            drive1(r1, 0, 1);
            if (k < 2) begin
                exp_q.push_back({r0, 1'b0, 1'b1});
                exp_q.push_back({r1, 1'b0, 1'b1});
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("ovf_count", count, 4);
        check("ovf_full", full, 1);
        check("ovf_drop_cnt", drop_cnt, 2);
        check("ovf_head_hold_pc", upd_info[31:0], 32'h1000);

        // Full with concurrent pop: push accepted into the freed slot
        step();
        upd_ready = 1;
        r0 = mk(0, 32'h1130, 1, 32'h1030);
        drive0(r0, 0, 1);
        exp_q.push_back({r0, 1'b0, 1'b1});
        step();
        upd_ready = 0;
        idle_inputs();
        @(negedge clk);
        check("fullpop_count", count, 4);
        check("fullpop_full", full, 1);
        check("fullpop_drop_cnt", drop_cnt, 2);

        // Saturation of the 2-bit drop counter
        step();
        drive0(mk(1, 32'h2100, 1, 32'h2000), 0, 1);
        drive1(mk(1, 32'h2104, 1, 32'h2004), 0, 1);
        step();
        idle_inputs();
        @(negedge clk);
        check("sat_drop_cnt", drop_cnt, 3);
        check("sat_count", count, 4);
        step();
        drive0(mk(1, 32'h2110, 1, 32'h2010), 1, 0);
        step();
        idle_inputs();
        @(negedge clk);
        check("sat_hold_drop_cnt", drop_cnt, 3);

        // Drain the remaining four records in order
        step();
        upd_ready = 1;
        repeat (4) @(negedge clk);
        step();
        @(negedge clk);
        check("drain_count", count, 0);
        check("drain_valid", upd_valid, 0);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_empty", 68'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
